// File: rtl/data_mem_ctrl.sv
// Clocked data memory for the RISC-Z datapath, between the MEM stage and the
// register write-back mux. Byte-enabled writes, configurable read latency,
// req/ready/valid handshake and out-of-range / no-op error reporting.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   MemReq             request strobe, accepted when MemReq & MemReady at an edge
//   MemW, MemR         write / read qualifiers (both set = read-before-write)
//   MemAddr            word address; addresses >= DEPTH are errors, never wrap
//   MemIn, MemBE       write data and per-byte write enables
//   MemReady           request can be accepted this cycle
//   MemValid           one-cycle completion pulse
//   MemErr             qualifies MemValid: bad address or MemW=MemR=0
//   MemOut             read data, holds the last completed in-range read
module data_mem_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DEPTH    = 1000,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReq,
    input  logic                  MemW,
    input  logic                  MemR,
    input  logic [ADDR_W-1:0]     MemAddr,
    input  logic [DATA_W-1:0]     MemIn,
    input  logic [DATA_W/8-1:0]   MemBE,
    output logic                  MemReady,
    output logic                  MemValid,
    output logic                  MemErr,
    output logic [DATA_W-1:0]     MemOut
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 3;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic {IDLE, RBUSY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   rbuf_q, rbuf_d;
    logic                rerr_q, rerr_d;

    logic                accept;
    logic                in_range;
    logic                we;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign accept   = MemReq & ready_q;
    assign in_range = MemAddr < DEPTH_A;
    assign idx      = IDX_W'(MemAddr);
    // Sampled before the write edge, which gives read-before-write for free.
    assign rd_word  = in_range ? mem[idx] : '0;

    // Next-state and output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        out_d   = out_q;
        rbuf_d  = rbuf_q;
        rerr_d  = rerr_q;
        we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!MemR && !MemW) begin
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        we = MemW & in_range;
                        if (!MemR) begin
                            valid_d = 1'b1;
                            err_d   = ~in_range;
                        end else if (READ_LAT == 1) begin
                            valid_d = 1'b1;
                            err_d   = ~in_range;
                            if (in_range) out_d = rd_word;
                        end else begin
                            // Data is captured now; RAM cannot change while busy.
                            state_d = RBUSY;
                            cnt_d   = CNT_W'(READ_LAT - 1);
                            rbuf_d  = rd_word;
                            rerr_d  = ~in_range;
                        end
                    end
                end
            end
            RBUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    err_d   = rerr_q;
                    if (!rerr_q) out_d = rbuf_q;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            out_q   <= '0;
            rbuf_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            out_q   <= out_d;
            rbuf_q  <= rbuf_d;
            rerr_q  <= rerr_d;
        end
    end

    // RAM array, byte-granular writes, contents not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (MemBE[i]) mem[idx][i*8 +: 8] <= MemIn[i*8 +: 8];
            end
        end
    end

    assign MemReady = ready_q;
    assign MemValid = valid_q;
    assign MemErr   = err_q;
    assign MemOut   = out_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: READ_LAT=2 and READ_LAT=1 instances share stimulus;
// a transaction-level model predicts completions per instance.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReq, MemW, MemR;
    logic [15:0] MemAddr, MemIn;
    logic [1:0]  MemBE;
    logic        rdy  [2];
    logic        vld  [2];
    logic        er   [2];
    logic [15:0] dout [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1000), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .MemReq(MemReq), .MemW(MemW), .MemR(MemR),
        .MemAddr(MemAddr), .MemIn(MemIn), .MemBE(MemBE),
        .MemReady(rdy[0]), .MemValid(vld[0]), .MemErr(er[0]), .MemOut(dout[0]));

    data_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(1000), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .MemReq(MemReq), .MemW(MemW), .MemR(MemR),
        .MemAddr(MemAddr), .MemIn(MemIn), .MemBE(MemBE),
        .MemReady(rdy[1]), .MemValid(vld[1]), .MemErr(er[1]), .MemOut(dout[1]));

    task automatic chk(input string name, input int i, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endtask

    // Model: each accepted request completes at a due edge with a result.
    int          ecnt = 0;
    int          free_at  [2];
    int          lat      [2];
    logic [15:0] mem_m    [2][1000];
    logic        pend     [2];
    int          pend_due [2];
    logic        pend_err [2];
    logic        pend_hd  [2];
    logic [15:0] pend_d   [2];
    logic        ev_v     [2];
    logic        ev_e     [2];
    logic [15:0] out_m    [2];

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        for (int i = 0; i < 2; i++) begin
            free_at[i] = 1 << 30;
            pend[i] = 1'b0;
            ev_v[i] = 1'b0;
            ev_e[i] = 1'b0;
            out_m[i] = '0;
        end
        forever begin
            @(posedge clk);
            ecnt++;
            for (int i = 0; i < 2; i++) begin
                ev_v[i] = 1'b0;
                ev_e[i] = 1'b0;
                if (rst) begin
                    free_at[i] = ecnt + 1;
                    pend[i] = 1'b0;
                    out_m[i] = '0;
                end else begin
                    if (MemReq && (ecnt - 1 >= free_at[i])) begin
                        automatic bit inr = (MemAddr < 16'd1000);
                        automatic logic [15:0] old = inr ? mem_m[i][MemAddr] : 16'h0;
                        pend[i] = 1'b1;
                        pend_due[i] = ecnt + (MemR ? lat[i] : 1) - 1;
                        pend_err[i] = (!MemR && !MemW) || !inr;
                        pend_hd[i] = MemR && inr;
                        pend_d[i] = old;
                        if (MemW && inr) begin
                            if (MemBE[0]) mem_m[i][MemAddr][7:0]  = MemIn[7:0];
                            if (MemBE[1]) mem_m[i][MemAddr][15:8] = MemIn[15:8];
                        end
                        if (MemR) free_at[i] = ecnt + lat[i] - 1;
                    end
                    if (pend[i] && pend_due[i] == ecnt) begin
                        ev_v[i] = 1'b1;
                        ev_e[i] = pend_err[i];
                        if (pend_hd[i]) out_m[i] = pend_d[i];
                        pend[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle compare plus completion logging for the directed checks.
    int          vcnt     [2] = '{0, 0};
    int          lowcnt   [2] = '{0, 0};
    logic        last_err [2] = '{1'b0, 1'b0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    chk("rst_ready", i, 16'(rdy[i]), 16'h0);
                    chk("rst_valid", i, 16'(vld[i]), 16'h0);
                    chk("rst_out", i, dout[i], 16'h0);
                end else begin
                    chk("ready", i, 16'(rdy[i]), 16'(ecnt >= free_at[i]));
                    chk("valid", i, 16'(vld[i]), 16'(ev_v[i]));
                    chk("err", i, 16'(er[i]), 16'(ev_e[i]));
                    chk("out", i, dout[i], out_m[i]);
                    if (!rdy[i]) lowcnt[i]++;
                    if (vld[i]) begin
                        vcnt[i]++;
                        last_err[i] = er[i];
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string name, input logic w, input logic r,
                      input logic [15:0] a, input logic [15:0] d, input logic [1:0] be,
                      input logic [15:0] exp_out, input logic exp_err);
        int v0 [2];
        for (int i = 0; i < 2; i++) v0[i] = vcnt[i];
        MemReq = 1'b1; MemW = w; MemR = r; MemAddr = a; MemIn = d; MemBE = be;
        step();
        MemReq = 1'b0; MemW = 1'b0; MemR = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 2; i++) begin
            chk({name, "_vcnt"}, i, 16'(vcnt[i] - v0[i]), 16'd1);
            chk({name, "_err"}, i, 16'(last_err[i]), 16'(exp_err));
            chk({name, "_out"}, i, dout[i], exp_out);
        end
    endtask

    initial begin
        int v0 [2];
        rst = 1'b1; MemReq = 1'b0; MemW = 1'b0; MemR = 1'b0;
        MemAddr = '0; MemIn = '0; MemBE = '0;
        step(); step(); step();
        rst = 1'b0;
        step(); step();

        op("wr0",   1, 0, 16'd0,   16'h0A0A, 2'b11, 16'h0000, 1'b0);
        op("wr999", 1, 0, 16'd999, 16'h0999, 2'b11, 16'h0000, 1'b0);

        op("t1_wr", 1, 0, 16'd5, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
        lowcnt[0] = 0; lowcnt[1] = 0;
        op("t1_rd", 0, 1, 16'd5, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
        chk("t1_ready_low", 0, 16'(lowcnt[0]), 16'd1);
        chk("t1_ready_low", 1, 16'(lowcnt[1]), 16'd0);

        op("t2_wr", 1, 0, 16'd5, 16'h1234, 2'b01, 16'hBEEF, 1'b0);
        op("t2_rd", 0, 1, 16'd5, 16'h0000, 2'b00, 16'hBE34, 1'b0);

        op("t3_rw", 1, 1, 16'd5, 16'hAAAA, 2'b11, 16'hBE34, 1'b0);
        op("t3_rd", 0, 1, 16'd5, 16'h0000, 2'b00, 16'hAAAA, 1'b0);

        op("t4_wr_oor", 1, 0, 16'd1000, 16'h5555, 2'b11, 16'hAAAA, 1'b1);
        op("t4_rd_oor", 0, 1, 16'd1000, 16'h0000, 2'b00, 16'hAAAA, 1'b1);
        op("t4_rd999",  0, 1, 16'd999,  16'h0000, 2'b00, 16'h0999, 1'b0);
        op("t4_rd0",    0, 1, 16'd0,    16'h0000, 2'b00, 16'h0A0A, 1'b0);

        op("nop", 0, 0, 16'd7, 16'hFFFF, 2'b11, 16'h0A0A, 1'b1);

        // Back-to-back writes, one per cycle.
        for (int i = 0; i < 2; i++) begin
            v0[i] = vcnt[i];
            lowcnt[i] = 0;
        end
        for (int k = 1; k <= 3; k++) begin
            MemReq = 1'b1; MemW = 1'b1; MemR = 1'b0;
            MemAddr = 16'(k); MemIn = 16'(k); MemBE = 2'b11;
            step();
        end
        MemReq = 1'b0; MemW = 1'b0;
        step(); step();
        for (int i = 0; i < 2; i++) begin
            chk("t5_vcnt", i, 16'(vcnt[i] - v0[i]), 16'd3);
            chk("t5_ready_low", i, 16'(lowcnt[i]), 16'd0);
        end
        op("t5_rd1", 0, 1, 16'd1, 16'h0000, 2'b00, 16'h0001, 1'b0);
        op("t5_rd2", 0, 1, 16'd2, 16'h0000, 2'b00, 16'h0002, 1'b0);
        op("t5_rd3", 0, 1, 16'd3, 16'h0000, 2'b00, 16'h0003, 1'b0);

        // Reset during a read.
        v0[0] = vcnt[0];
        MemReq = 1'b1; MemR = 1'b1; MemW = 1'b0; MemAddr = 16'd1;
        step();
        MemReq = 1'b0; MemR = 1'b0;
        rst = 1'b1;
        step(); step();
        chk("t6_no_valid", 0, 16'(vcnt[0] - v0[0]), 16'd0);
        for (int i = 0; i < 2; i++) chk("t6_out_zero", i, dout[i], 16'h0000);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) chk("t6_ready_held", i, 16'(rdy[i]), 16'h0);
        step();
        for (int i = 0; i < 2; i++) chk("t6_ready_up", i, 16'(rdy[i]), 16'h1);
        op("t6_rd1", 0, 1, 16'd1, 16'h0000, 2'b00, 16'h0001, 1'b0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
